// File: rtl/bias_act_stream.sv
// bias_act_stream: per-channel bias add, optional ReLU and saturation on a
// valid/ready activation stream. One output register gives 1-cycle latency
// and full throughput while the downstream keeps out_ready high.
module bias_act_stream #(
    parameter int N_CH   = 10,
    parameter int DATA_W = 32,
    parameter int BIAS_W = 32,
    parameter int OUT_W  = 32,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bias_we,
    input  logic [CH_W-1:0]   bias_addr,
    input  logic [BIAS_W-1:0] bias_data,
    input  logic              relu_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic [CH_W-1:0]   out_ch,
    output logic              err_align,
    output logic [15:0]       sat_cnt
);
    // Sum width large enough that the add can never overflow.
    localparam int W = ((DATA_W > BIAS_W) ? DATA_W : BIAS_W) + 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
    // Output range limits, sign-extended to the sum width.
    localparam logic signed [W-1:0] MAX_P = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_N = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [BIAS_W-1:0]     r_bias [N_CH];
    logic [CH_W-1:0]       r_ch;
    logic                  r_err;
    logic [15:0]           r_sat;
    logic                  r_out_valid;
    logic [OUT_W-1:0]      r_out_data;
    logic                  r_out_last;
    logic [CH_W-1:0]       r_out_ch;

    logic [N_CH-1:0]       w_bias_wr;
    logic                  w_accept;
    logic                  w_is_last_ch;
    logic [BIAS_W-1:0]     w_bias_sel;
    logic signed [W-1:0]   w_sum;
    logic signed [W-1:0]   w_act;
    logic                  w_hi;
    logic                  w_lo;
    logic [OUT_W-1:0]      w_res;

    // Per-entry write decode; addresses beyond the bank match no entry.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_wr
            assign w_bias_wr[gi] = bias_we && (bias_addr == CH_W'(gi));
        end
    endgenerate

    assign in_ready     = !r_out_valid || out_ready;
    assign w_accept     = in_valid && in_ready;
    assign w_is_last_ch = (r_ch == LAST_CH);
    assign w_bias_sel   = r_bias[r_ch];

    // Datapath: widen, add, optional ReLU, then clamp to the output range.
    always_comb begin
        w_sum = W'($signed(in_data)) + W'($signed(w_bias_sel));
        w_act = (relu_en && w_sum[W-1]) ? '0 : w_sum;
        w_hi  = (w_act > MAX_P);
        w_lo  = (w_act < MIN_N);
        if (w_hi)
            w_res = MAX_P[OUT_W-1:0];
        else if (w_lo)
            w_res = MIN_N[OUT_W-1:0];
        else
            w_res = w_act[OUT_W-1:0];
    end

    // Bias bank; a beat accepted in the write cycle already read the old value.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (!rst)
                r_bias[i] <= '0;
            else if (w_bias_wr[i])
                r_bias[i] <= bias_data;
        end
    end

    // Channel tracking, sticky alignment error and saturation counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ch  <= '0;
            r_err <= 1'b0;
            r_sat <= '0;
        end else if (w_accept) begin
            r_ch <= (in_last || w_is_last_ch) ? '0 : r_ch + CH_W'(1);
            if (in_last != w_is_last_ch)
                r_err <= 1'b1;
            if ((w_hi || w_lo) && (r_sat != 16'hFFFF))
                r_sat <= r_sat + 16'd1;
        end
    end

    // Output register: load on accept, drop valid once taken, hold when stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res;
            r_out_last  <= in_last;
            r_out_ch    <= r_ch;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_ch    = r_out_ch;
    assign err_align = r_err;
    assign sat_cnt   = r_sat;

endmodule

// File: tb/tb_bias_act_stream.sv
// Testbench for bias_act_stream with a 16-bit output so saturation is easy
// to reach. Expected beats come from an arithmetic model kept in a queue.
module tb_bias_act_stream;
    localparam int N_CH = 10;
    localparam int CH_W = $clog2(N_CH);
    localparam longint OMAX = 32767;
    localparam longint OMIN = -32768;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            bias_we = 1'b0;
    logic [CH_W-1:0] bias_addr = '0;
    logic [31:0]     bias_data = '0;
    logic            relu_en = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_data = '0;
    logic            in_last = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [15:0]     out_data;
    logic            out_last;
    logic [CH_W-1:0] out_ch;
    logic            err_align;
    logic [15:0]     sat_cnt;

    bias_act_stream #(.N_CH(N_CH), .DATA_W(32), .BIAS_W(32), .OUT_W(16)) dut (
        .clk(clk), .rst(rst), .bias_we(bias_we), .bias_addr(bias_addr),
        .bias_data(bias_data), .relu_en(relu_en), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_ch(out_ch), .err_align(err_align),
        .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint data;
        int     ch;
        bit     last;
        int     sat;
        bit     err;
    } beat_t;

    beat_t  exp_q[$];
    longint m_bias [N_CH];
    int     m_ch;
    bit     m_err;
    int     m_sat;
    int     n_tests = 0;
    int     n_fail  = 0;
    bit     rand_done;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: what one accepted beat must produce, from plain arithmetic.
    function automatic void model_accept(input logic [31:0] d, input bit last, input bit relu);
        beat_t  b;
        longint s;
        bit     clamped;
        s = longint'($signed(d)) + m_bias[m_ch];
        if (relu && s < 0) s = 0;
        clamped = (s > OMAX) || (s < OMIN);
        if (s > OMAX) s = OMAX;
        if (s < OMIN) s = OMIN;
        if (clamped && m_sat < 65535) m_sat++;
        if (last != (m_ch == N_CH - 1)) m_err = 1'b1;
        b.data = s; b.ch = m_ch; b.last = last; b.sat = m_sat; b.err = m_err;
        exp_q.push_back(b);
        m_ch = (last || m_ch == N_CH - 1) ? 0 : m_ch + 1;
        if (bias_we && int'(bias_addr) < N_CH)
            m_bias[bias_addr] = longint'($signed(bias_data));
    endfunction

    function automatic void model_reset();
        foreach (m_bias[i]) m_bias[i] = 0;
        m_ch = 0; m_err = 1'b0; m_sat = 0;
        exp_q.delete();
    endfunction

    // All driving tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [31:0] d, input bit last, input bit relu);
        int guard = 0;
        in_valid = 1'b1; in_data = d; in_last = last; relu_en = relu;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_wait", in_ready, 1);
        model_accept(d, last, relu);
        @(posedge clk); #1;
        in_valid = 1'b0; bias_we = 1'b0;
    endtask

    task automatic write_bias(input int addr, input longint val);
        bias_we = 1'b1; bias_addr = CH_W'(addr); bias_data = 32'(val);
        @(posedge clk); #1;
        if (addr < N_CH) m_bias[addr] = longint'($signed(32'(val)));
        bias_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        model_reset();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_err_align", err_align, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic send_vector(input logic [31:0] base, input bit relu);
        for (int i = 0; i < N_CH; i++)
            send(base + 32'(i), i == N_CH - 1, relu);
    endtask

    // Output monitor: every delivered beat must match the next expected one;
    // a stalled beat must stay put and hold off the input.
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic [3:0]  prev_ch;
    logic        prev_last;
    always @(negedge clk) begin
        beat_t b;
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_data_held", out_data, prev_data);
                chk("stall_ch_held", out_ch, prev_ch);
                chk("stall_last_held", out_last, prev_last);
            end
            if (out_valid && !out_ready)
                chk("stall_in_ready_low", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    chk("out_data", $signed(out_data), b.data);
                    chk("out_ch", out_ch, b.ch);
                    chk("out_last", out_last, b.last);
                    chk("sat_cnt", sat_cnt, b.sat);
                    chk("err_align", err_align, b.err);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_ch    = out_ch;
            prev_last  = out_last;
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Bias ramp i*100 and data i+1 -> 101*i+1 on every channel.
        for (int i = 0; i < N_CH; i++) write_bias(i, i * 100);
        send_vector(32'd1, 1'b0);
        drain();

        // Negative sum with and without ReLU on channel 3.
        write_bias(3, -50);
        for (int i = 0; i < N_CH; i++) send((i == 3) ? 32'd20 : 32'(i), i == N_CH - 1, 1'b0);
        for (int i = 0; i < N_CH; i++) send((i == 3) ? 32'd20 : 32'(i), i == N_CH - 1, 1'b1);
        drain();

        // Saturation at both ends of the 16-bit range.
        write_bias(0, 32000);
        write_bias(1, -32000);
        for (int i = 0; i < N_CH; i++)
            send((i == 0) ? 32'd1000 : (i == 1) ? -32'sd1000 : 32'(i), i == N_CH - 1, 1'b0);
        drain();

        // Backpressure: out_ready pattern 1,0,0,1 while a vector streams.
        rand_done = 1'b0;
        fork
            begin
                send_vector(32'd7, 1'b0);
                rand_done = 1'b1;
            end
            begin
                int k = 0;
                while (!rand_done) begin
                    out_ready = (k % 4 == 1 || k % 4 == 2) ? 1'b0 : 1'b1;
                    k++;
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Early in_last on channel 5, then the stream restarts at channel 0.
        for (int i = 0; i <= 5; i++) send(32'(i), i == 5, 1'b0);
        drain();
        chk("err_sticky_early_last", err_align, 1);
        send_vector(32'd3, 1'b0);
        drain();
        chk("err_still_set", err_align, 1);

        // Ten beats with no in_last: error appears on channel 9.
        do_reset();
        for (int i = 0; i < N_CH; i++) send(32'(i), 1'b0, 1'b0);
        drain();
        chk("err_missing_last", err_align, 1);

        // Bias write colliding with the channel-2 beat, plus an out-of-range write.
        do_reset();
        for (int i = 0; i < N_CH; i++) begin
            if (i == 2) begin
                bias_we = 1'b1; bias_addr = 4'd2; bias_data = 32'd7;
            end
            send(32'd1, i == N_CH - 1, 1'b0);
        end
        write_bias(12, 999);
        send_vector(32'd1, 1'b0);
        drain();

        // Reset mid-vector discards the partial vector and zeroes the bank.
        write_bias(0, 1234);
        for (int i = 0; i < 4; i++) send(32'(i), 1'b0, 1'b0);
        do_reset();
        send(32'd5, 1'b0, 1'b0);
        drain();
        for (int i = 1; i < N_CH; i++) send(32'(i), i == N_CH - 1, 1'b0);
        drain();

        // Randomized vectors, biases, ReLU and downstream readiness.
        for (int v = 0; v < 12; v++) begin
            for (int j = 0; j < 3; j++)
                write_bias($urandom_range(0, N_CH - 1), longint'($urandom_range(0, 80000)) - 40000);
            rand_done = 1'b0;
            fork
                begin
                    for (int i = 0; i < N_CH; i++)
                        send(32'($urandom_range(0, 80000)) - 32'd40000, i == N_CH - 1,
                             bit'($urandom_range(0, 1)));
                    rand_done = 1'b1;
                end
                begin
                    while (!rand_done) begin
                        out_ready = bit'($urandom_range(0, 1));
                        @(posedge clk); #1;
                    end
                    out_ready = 1'b1;
                end
            join
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case anything above never returns.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
